// File: rtl/seq_word_serializer_if.sv
// Handshake/serial bus for seq_word_serializer: parallel word in, bit stream out.
interface seq_word_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             dout;
    logic             dout_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, dout, dout_valid, word_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, dout, dout_valid, word_done, busy
    );
endinterface

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial front end with a one-word holding buffer for gapless streaming.
// Define SER_PARITY_EN to append an even-parity bit after every word.
module seq_word_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_word_serializer_if.slave bus
);
`ifdef SER_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif
    localparam int unsigned   CW      = $clog2(LAST + 1);
    localparam logic [CW-1:0] LastCnt = CW'(LAST);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic             last_bit;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign accept   = bus.data_valid && !hold_full_q;
    assign last_bit = (state_q == StShift) && (bitcnt_q == LastCnt);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        bitcnt_d    = bitcnt_q;
        hold_full_d = hold_full_q;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d  = bus.data_in;
                    bitcnt_d = '0;
                    state_d  = StShift;
`ifdef SER_PARITY_EN
                    par_d    = ^bus.data_in;
`endif
                end
            end
            StShift: begin
                if (last_bit) begin
                    // hold_full blocks accept, so the two reload sources never collide
                    bitcnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
`ifdef SER_PARITY_EN
                        par_d       = ^hold_q;
`endif
                    end else if (accept) begin
                        shreg_d = bus.data_in;
`ifdef SER_PARITY_EN
                        par_d   = ^bus.data_in;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    shreg_d  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, shreg_q[WIDTH-1:1]};
                    bitcnt_d = bitcnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = bus.data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.data_ready = !hold_full_q;
        bus.busy       = (state_q == StShift) || hold_full_q;
        bus.dout_valid = (state_q == StShift);
        bus.word_done  = last_bit;
        bus.dout       = IDLE_BIT;
        if (state_q == StShift) begin
            bus.dout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SER_PARITY_EN
            if (bitcnt_q == LastCnt) begin
                bus.dout = par_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            hold_q      <= '0;
            bitcnt_q    <= '0;
            hold_full_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            bitcnt_q    <= bitcnt_d;
            hold_full_q <= hold_full_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_word_serializer.sv
// Self-checking bench for seq_word_serializer: word table plus reset/hold corner sequences.
module tb_seq_word_serializer;
    localparam int unsigned W    = 8;
    localparam bit          MSB  = 1'b1;
    localparam bit          IDLE = 1'b0;
`ifdef SER_PARITY_EN
    localparam int unsigned NTOT = W + 1;
`else
    localparam int unsigned NTOT = W;
`endif

    typedef struct {
        logic b;
        logic done;
    } exp_t;

    typedef struct {
        logic [W-1:0] word;
        int           gap;
        logic         par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t exp_q[$];
    exp_t e;
    vec_t tab[12];

    seq_word_serializer_if #(.WIDTH(W)) bus ();

    seq_word_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(MSB),
        .IDLE_BIT (IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Stream monitor: every pending expected bit must be on dout with no gap.
    always @(negedge clk) begin
        if (mon_en) begin
            nvec++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (bus.dout_valid !== 1'b1 || bus.dout !== e.b || bus.word_done !== e.done) begin
                    nerr++;
                    $display("FAIL stream_bit @%0t: valid=%b dout=%b done=%b, required 1 %b %b",
                             $time, bus.dout_valid, bus.dout, bus.word_done, e.b, e.done);
                end
            end else if (bus.dout_valid !== 1'b0 || bus.dout !== IDLE || bus.word_done !== 1'b0) begin
                nerr++;
                $display("FAIL idle_line @%0t: valid=%b dout=%b done=%b, required 0 %b 0",
                         $time, bus.dout_valid, bus.dout, bus.word_done, IDLE);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s @%0t: got %b, required %b", name, $time, act, req);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic par);
        exp_t x;
        for (int i = 0; i < W; i++) begin
            x.b    = MSB ? w[W-1-i] : w[i];
            x.done = (i == NTOT - 1);
            exp_q.push_back(x);
        end
`ifdef SER_PARITY_EN
        x.b    = par;
        x.done = 1'b1;
        exp_q.push_back(x);
`else
        x.b = par;
`endif
    endtask

    // Called just after a clock edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] w, input logic par);
        int t = 0;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        while (bus.data_ready !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: data_ready=%b, required 1", bus.data_ready);
        end else begin
            step();
            push_word(w, par);
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        nvec++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: %0d bits pending, required 0", exp_q.size());
        end
        step();
        step();
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_ready", bus.data_ready, 1'b1);
    endtask

    initial begin
        tab[0]  = '{word: 8'hB6, gap: 12, par: 1'b1};
        tab[1]  = '{word: 8'hD9, gap: 0,  par: 1'b1};
        tab[2]  = '{word: 8'h6C, gap: 14, par: 1'b0};
        tab[3]  = '{word: 8'hDB, gap: 0,  par: 1'b0};
        tab[4]  = '{word: 8'h6D, gap: 0,  par: 1'b1};
        tab[5]  = '{word: 8'h07, gap: 15, par: 1'b1};
        tab[6]  = '{word: 8'h03, gap: 3,  par: 1'b0};
        tab[7]  = '{word: 8'hFF, gap: 0,  par: 1'b0};
        tab[8]  = '{word: 8'h00, gap: 0,  par: 1'b0};
        tab[9]  = '{word: 8'h80, gap: 5,  par: 1'b1};
        tab[10] = '{word: 8'hA5, gap: 0,  par: 1'b0};
        tab[11] = '{word: 8'h01, gap: 20, par: 1'b1};

        // Reset held with a valid word presented: nothing may be accepted.
        bus.data_in    = 8'hFF;
        bus.data_valid = 1'b1;
        #2;
        step();
        step();
        chk("rst_dout", bus.dout, IDLE);
        chk("rst_dout_valid", bus.dout_valid, 1'b0);
        chk("rst_word_done", bus.word_done, 1'b0);
        chk("rst_ready", bus.data_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        bus.data_valid = 1'b0;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 12; i++) begin
            send(tab[i].word, tab[i].par);
            repeat (tab[i].gap) step();
        end
        drain();

        // Back-to-back: second word lands in hold, ready drops until the reload edge.
        send(8'hD9, 1'b1);
        send(8'h6C, 1'b0);
        chk("hold_ready_low", bus.data_ready, 1'b0);
        chk("hold_busy", bus.busy, 1'b1);
        repeat (NTOT - 2) step();
        chk("hold_ready_before_reload", bus.data_ready, 1'b0);
        step();
        chk("ready_after_reload", bus.data_ready, 1'b1);
        drain();

        // Mid-word reset with a word held: everything discarded, no tail bits.
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        chk("mid_hold_full", bus.data_ready, 1'b0);
        step();
        step();
        mon_en = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_dout", bus.dout, IDLE);
        chk("mid_rst_valid", bus.dout_valid, 1'b0);
        chk("mid_rst_ready", bus.data_ready, 1'b1);
        chk("mid_rst_busy", bus.busy, 1'b0);
        mon_en = 1'b1;
        repeat (3 * NTOT) step();

        // Stream resumes cleanly after the reset.
        send(8'hB6, 1'b1);
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_word_serializer.md
Name: seq_word_serializer

Overview:
- Parallel-to-serial front end for the bit-serial pattern detectors (e.g. seq_detect_mealy).
- Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock on dout, which connects directly to the detector's din.
- A one-word holding buffer lets back-to-back words stream with no idle gap, so patterns that straddle word boundaries are still seen by the detector.

Parameters:
WIDTH, 8, bits per input word (≥2)
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first
IDLE_BIT, 0, level driven on dout when no word is being shifted

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in valid
data_ready  output  1  block can accept a word this cycle
dout  output  1  serial bit stream (to detector din)
dout_valid  output  1  dout carries a payload bit this cycle
word_done  output  1  one-cycle pulse while the last bit of a word is on dout
busy  output  1  shifting or holding a word

Behaviour:
- Reset: one clock is synchronous and active-high; reset clears all state on the next clk edge regardless of other inputs.
  - Post-reset values: dout=IDLE_BIT, dout_valid=0, word_done=0, busy=0, data_ready=1; shift register, bit counter and holding buffer cleared; state=IDLE.
- Registers:
  - shreg[WIDTH]
  - bitcnt, $clog2(WIDTH) bits
  - hold[WIDTH] and hold_full
  - state ∈ {IDLE, SHIFT}
- Output paths:
  - All outputs are decoded from registers only; no combinational path from data_in/data_valid to any output.
  - data_ready = !hold_full.
- Handshake: a transfer occurs on an edge where data_valid && data_ready. data_in must be held stable while data_valid=1 and ready=0.
- IDLE:
  - dout=IDLE_BIT, dout_valid=0.
  - On transfer: shreg←data_in, bitcnt←0, state→SHIFT.
  - Latency: first bit appears on dout in the cycle immediately after the accepting edge.
- SHIFT:
  - dout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; dout_valid=1.
  - Each edge: shift toward the output end, bitcnt++.
  - word_done=1 while bitcnt==WIDTH-1.
- Transfer while SHIFT, non-last edge (bitcnt≠WIDTH-1): word goes to hold, hold_full←1.
- Last-bit edge (bitcnt==WIDTH-1):
  - If hold_full: shreg←hold, hold_full←0, bitcnt←0, stay SHIFT.
  - Else if a transfer occurs on this edge: shreg←data_in directly, bitcnt←0, stay SHIFT.
  - Else: state→IDLE.
  - In every case the stream is gapless, exactly WIDTH valid bits per word.
- Simultaneous events: hold_full=1 forces ready=0, so no accept can collide with a hold→shreg reload. Ready rises in the cycle after the reload.
- busy = (state==SHIFT) || hold_full.
- Reset mid-word: partial word and held word are discarded; no truncated tail bits are emitted after the reset edge.
- Throughput: 1 word per WIDTH cycles sustained; the holding buffer gives 1 word of elasticity.

Optional Feature:
- Macro: SER_PARITY_EN
- Defined:
  - After the last data bit of each word, one extra even-parity bit (XOR of the word) is driven with dout_valid=1.
  - Each word therefore occupies WIDTH+1 cycles; bitcnt range is extended accordingly.
  - word_done pulses on the parity bit, not on the last data bit.
  - The reload/return-to-IDLE decision moves to the parity-bit edge.
- Undefined: no parity bit; exactly WIDTH bits per word as above.

Test Plan:
1. Reset check: hold rst=1 for 2 edges with data_valid=1 → dout=0, dout_valid=0, data_ready=1, busy=0, and no word accepted.
2. Single word, MSB_FIRST=1: data_in=8'hB6 accepted → dout=1,0,1,1,0,1,1,0 on the 8 cycles after accept; dout_valid high exactly 8 cycles; word_done only on the 8th; then dout=0, busy=0.
3. Back-to-back: 8'hD9 then 8'h6C with data_valid held high → 16 contiguous valid bits 1101100101101100 with no gap; data_ready low while hold_full; word_done pulses at bits 8 and 16.
4. Mid-word reset: rst=1 for one edge during bit 4 of 8'hFF with a word held → next cycle dout=0, dout_valid=0, data_ready=1; no residual bits afterwards.
5. Chained to seq_detect_mealy: words 8'hDB, 8'h6D streamed gaplessly into din → detector y pulses on the same cycles as a golden bit-level model, including the match straddling the word boundary.
6. SER_PARITY_EN defined: 8'h07 → 9 valid bits 0,0,0,0,0,1,1,1,1 (parity=1); 8'h03 → 9th bit 0; word_done on the 9th bit only.
